// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared constants and state encoding for the deser8_demux receiver
//
// Contents:
//   WIDTH    bits per frame (power of 2)
//   IDX_W    width of the bit index / frame counter
//   state_e  receiver FSM states (IDLE, COLLECT, STALL)

package deser_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = $clog2(WIDTH);

    // IDLE    : no partial frame, next bit must be index 0
    // COLLECT : partial frame in the shadow, next bit must be index idx
    // STALL   : complete frame in the shadow, waiting for the output slot
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        STALL   = 2'b10
    } state_e;

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - binary index to one-hot decoder with a global enable
//
// Ports:
//   en_i   input   1      enable; all outputs are 0 when low
//   sel_i  input   IN_W   binary index
//   dec_o  output  OUT_W  one-hot vector, bit sel_i set when en_i is high

module decoder_onehot #(
    parameter int OUT_W = 8,
    parameter int IN_W  = $clog2(OUT_W)
) (
    input  logic             en_i,
    input  logic [IN_W-1:0]  sel_i,
    output logic [OUT_W-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dec_o[i] = en_i && (sel_i == IN_W'(i));
        end
    end

endmodule

// File: rtl/deser8_demux.sv
// rtl/deser8_demux.sv - serial-to-parallel receiver with in-order bit check and one-entry output slot
//
// Ports:
//   clk          input   1      system clock, rising edge
//   reset_n      input   1      asynchronous active-low reset
//   in_bit       input   1      serial data bit
//   in_sel       input   IDX_W  index of in_bit within the frame
//   in_valid     input   1      in_bit/in_sel valid this cycle
//   in_ready     output  1      a bit can be accepted this cycle (state != STALL)
//   frame_abort  input   1      synchronous discard of the partial frame
//   out_data     output  WIDTH  assembled frame
//   out_valid    output  1      out_data holds an unconsumed frame
//   out_ready    input   1      consumer takes out_data this cycle
//   err_order    output  1      one-cycle pulse after an out-of-order index is rejected
//   busy         output  1      partial or held frame in progress (state != IDLE)

module deser8_demux #(
    parameter int WIDTH = deser_pkg::WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_bit,
    input  logic [IDX_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_abort,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_order,
    output logic             busy
);

    import deser_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_order_q, err_order_d;

    logic             accept;
    logic             pop;
    logic             in_order;
    logic             wr_en;
    logic [WIDTH-1:0] bit_we;
    logic [WIDTH-1:0] shadow_merged;
    logic             load;
    logic [WIDTH-1:0] load_data;

    assign in_ready = (state_q != STALL);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;

    // idx_q is 0 in IDLE, so one comparison covers both the frame start
    // check (in_sel == 0) and the in-order check while collecting.
    // in_valid gates everything, so an X on in_sel never reaches state.
    assign in_order = accept && (in_sel == idx_q);
    assign wr_en    = in_order & ~frame_abort;

    decoder_onehot #(
        .OUT_W (WIDTH),
        .IN_W  (IDX_W)
    ) u_wr_dec (
        .en_i  (wr_en),
        .sel_i (in_sel),
        .dec_o (bit_we)
    );

    // Shadow with the incoming bit merged, so the final bit of a frame can
    // be forwarded to the output slot in the same cycle it arrives.
    assign shadow_merged = (shadow_q & ~bit_we) | (bit_we & {WIDTH{in_bit}});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        err_order_d = 1'b0;
        load        = 1'b0;
        load_data   = shadow_merged;

        if (frame_abort) begin
            // Abort beats a same-cycle accept; the output slot is untouched.
            state_d  = IDLE;
            idx_d    = '0;
            shadow_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_order) begin
                            shadow_d = shadow_merged;
                            idx_d    = idx_q + 1'b1;
                            state_d  = COLLECT;
                        end else begin
                            err_order_d = 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        if (in_order) begin
                            if (idx_q == LAST_IDX) begin
                                if (!out_valid_q || pop) begin
                                    load      = 1'b1;
                                    load_data = shadow_merged;
                                    shadow_d  = '0;
                                    idx_d     = '0;
                                    state_d   = IDLE;
                                end else begin
                                    // Slot occupied: park the complete frame.
                                    shadow_d = shadow_merged;
                                    idx_d    = '0;
                                    state_d  = STALL;
                                end
                            end else begin
                                shadow_d = shadow_merged;
                                idx_d    = idx_q + 1'b1;
                            end
                        end else begin
                            // No restart from the offending bit, even if it is index 0.
                            err_order_d = 1'b1;
                            shadow_d    = '0;
                            idx_d       = '0;
                            state_d     = IDLE;
                        end
                    end
                end

                STALL: begin
                    if (pop) begin
                        load      = 1'b1;
                        load_data = shadow_q;
                        shadow_d  = '0;
                        idx_d     = '0;
                        state_d   = IDLE;
                    end
                end

                default: begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            endcase
        end
    end

    // Output slot: a load in the same cycle as a pop keeps out_valid high.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = load_data;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_order_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_order_q <= err_order_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err_order = err_order_q;
    assign busy      = (state_q != IDLE);

endmodule
